// File: rtl/obi_rsp_filter.sv
// OBI instruction response filter: caps outstanding fetches and discards responses of flushed ones.
// Optional macro OBI_RSP_FILTER_REG_RSP_EN registers the forwarded response (1-cycle response latency).
package obi_rsp_filter_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
endpackage

module obi_rsp_filter
  import obi_rsp_filter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_pipeline,
  input  obi_req_t    core_req_i,
  output logic        core_gnt_o,
  output obi_req_t    bus_req_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        err_o
);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             err_q, err_d;
  logic             accept;
  logic             rsp_expected;
  logic             fwd;

  always_comb begin
    bus_req_o     = core_req_i;
    bus_req_o.req = core_req_i.req & ~clear_pipeline & (out_cnt_q < MAX_CNT);
    core_gnt_o    = bus_gnt_i & bus_req_o.req;
    accept        = core_gnt_o;

    // A response with nothing outstanding is a protocol violation and never touches the counters.
    rsp_expected  = bus_rvalid_i & (out_cnt_q != '0);
    fwd           = rsp_expected & (drop_cnt_q == '0) & ~clear_pipeline;

    out_cnt_d     = out_cnt_q + CNT_W'(accept) - CNT_W'(rsp_expected);
    drop_cnt_d    = drop_cnt_q;
    if (clear_pipeline) begin
      drop_cnt_d = out_cnt_q - CNT_W'(rsp_expected);
    end else if (rsp_expected && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end
    err_d         = err_q | (bus_rvalid_i & (out_cnt_q == '0));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef OBI_RSP_FILTER_REG_RSP_EN
  logic        rvalid_q;
  logic [31:0] rdata_q;

  // The forward decision is frozen here, so a flush during the output cycle cannot cancel it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= fwd;
      rdata_q  <= bus_rdata_i;
    end
  end

  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = rdata_q;
`else
  assign core_rvalid_o = fwd;
  assign core_rdata_o  = bus_rdata_i;
`endif
endmodule

// File: doc/obi_rsp_filter.md
# obi_rsp_filter

Response-side companion to the single-register OBI instruction request stage. Sits between that stage's registered request output and the instruction bus. It limits outstanding transactions to `MAX_OUTSTANDING` and tracks them with a counter. On `clear_pipeline` it discards the responses of every transaction already in flight, so the core never sees rvalid for a flushed fetch.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: maximum accepted-but-unanswered requests; legal range 1..15.
- `CNT_W`, localparam, derived: `$clog2(MAX_OUTSTANDING+1)`.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `clear_pipeline`  in  1  flush; same signal that drives the request stage.
- `core_req_i`  in  obi_req_t  request from the request register stage.
- `core_gnt_o`  out  1  grant back to the request register stage.
- `bus_req_o`  out  obi_req_t  request to the instruction bus.
- `bus_gnt_i`  in  1  bus grant.
- `bus_rvalid_i`  in  1  bus response valid.
- `bus_rdata_i`  in  32  bus response data.
- `core_rvalid_o`  out  1  filtered response valid to the core.
- `core_rdata_o`  out  32  response data to the core.
- `err_o`  out  1  sticky protocol error.

## Operation
- State:
  - `out_cnt` [CNT_W]: outstanding accepted requests.
  - `drop_cnt` [CNT_W]: responses still to discard.
  - `err_q`: sticky error flag.
- Request gating:
  - `bus_req_o` equals `core_req_i`, except `.req = core_req_i.req & ~clear_pipeline & (out_cnt < MAX_OUTSTANDING)`.
  - There is no same-cycle bypass: at full, the block stalls even if rvalid arrives that cycle.
- Grant: `core_gnt_o = bus_gnt_i & bus_req_o.req`. `accept = core_gnt_o`.
- Response classification, per cycle with `bus_rvalid_i=1`:
  - Unexpected, if `out_cnt==0`: sets `err_q`. It is not forwarded and does not change counters.
  - Dropped, if `drop_cnt>0` or `clear_pipeline=1`. If `drop_cnt>0`, `drop_cnt` decrements.
  - Otherwise forwarded.
- `out_cnt_next = out_cnt + accept - (bus_rvalid_i & out_cnt!=0)`. It never exceeds `MAX_OUTSTANDING` and never underflows.
- Flush:
  - In a cycle with `clear_pipeline=1`, `accept` is 0.
  - `drop_cnt_next = out_cnt - (bus_rvalid_i & out_cnt!=0)`. Every transaction still outstanding after this edge gets dropped.
  - Back-to-back flushes recompute the same way. They are idempotent.
- `core_rdata_o` passes `bus_rdata_i` whenever a response is forwarded. Otherwise it is don't-care.
- `err_o = err_q`. It clears only on reset.

## Timing
- Reset values:
  - `out_cnt=0`, `drop_cnt=0`, `err_o=0`, `core_rvalid_o=0`.
  - `bus_req_o.req` and `core_gnt_o` follow the combinational rules above.
- Latency: request path is combinational, 0 cycles. Response path is 0 cycles without the macro and 1 cycle with it.
- Simultaneous accept and rvalid: `out_cnt` unchanged.
- Simultaneous `clear_pipeline` and rvalid: that response is dropped and excluded from `drop_cnt_next`.
- Reset asserted mid-transaction: all counts clear. Bus responses still arriving after reset are flagged as unexpected (`err_o=1`), not forwarded.

## Configuration
- `OBI_RSP_FILTER_REG_RSP_EN` defined:
  - The forward decision is registered together with `bus_rdata_i`.
  - `core_rvalid_o` and `core_rdata_o` appear one cycle after `bus_rvalid_i`.
  - The register resets to `core_rvalid_o=0`.
  - A `clear_pipeline` in the output cycle does not cancel an already-registered forward.
- Undefined: the response path is combinational, with no extra flops.

## Test plan
- `MAX_OUTSTANDING=2`: 3 back-to-back requests with `bus_gnt_i=1` and no rvalid.
  - Required: 2 accepted, 3rd held with `bus_req_o.req=0`, `out_cnt=2`.
  - Then 1 rvalid with rdata=0xDEADBEEF: forwarded, and the 3rd request is accepted the next cycle.
- 2 outstanding, then `clear_pipeline` for 1 cycle, then 2 rvalids.
  - Required: `core_rvalid_o` stays 0, `drop_cnt` goes 2→1→0, `out_cnt=0`.
  - A 3rd rvalid after a new request is forwarded.
- `clear_pipeline` in the same cycle as an rvalid with 2 outstanding.
  - Required: that response is dropped, `drop_cnt=1`, and exactly one more response is dropped.
- Same-cycle accept and rvalid with `out_cnt=1`.
  - Required: `out_cnt` stays 1, the response is forwarded, and `core_gnt_o=1`.
- rvalid with `out_cnt=0`.
  - Required: `err_o` rises next cycle and stays 1.
  - Then assert `rst_i` asynchronously: `err_o`, `out_cnt` and `drop_cnt` are 0 immediately.
- With `OBI_RSP_FILTER_REG_RSP_EN`: rvalid at cycle N with rdata=0x12345678.
  - Required: `core_rvalid_o=1` and `core_rdata_o=0x12345678` at N+1 only.
